// File: rtl/dmem_if.sv
// Data-memory request/response bundle between a load/store requester (master)
// and the data memory (slave).
interface dmem_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        dmem_err;

    modport master (
        output dmem_addr, dmem_wdata, dmem_mask, dmem_ren, dmem_wen,
        input  dmem_rdata, dmem_valid, dmem_err
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_mask, dmem_ren, dmem_wen,
        output dmem_rdata, dmem_valid, dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised, byte-lane-writable data RAM answering the core's dmem bus:
// single-cycle writes, reads returned after a fixed READ_LATENCY.
module dmem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    dmem_if.slave dmem
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             unused_lo;
    logic             wr_en;
    logic             wr_err;
    logic             rd_vld;
    logic             rd_err;
    logic [31:0]      rd_word;
    logic [31:0]      wr_word_d;

    logic             pipe_vld;
    logic             pipe_err;
    logic [31:0]      pipe_data;

    logic             valid_d, valid_q;
    logic             err_d, err_q;
    logic [31:0]      rdata_d, rdata_q;

    // Accept stage: decode, and sample the addressed word at the accept edge.
    always_comb begin
        off       = dmem.dmem_addr - BASE_ADDR;
        in_range  = (off >> (IDX_W + 2)) == 32'd0;
        idx       = off[IDX_W+1:2];
        unused_lo = ^off[1:0];
        wr_en     = dmem.dmem_wen & ~dmem.dmem_ren & in_range;
        wr_err    = dmem.dmem_wen & ~dmem.dmem_ren & ~in_range;
        rd_vld    = dmem.dmem_ren;
        // ren together with wen is answered as an erroring read
        rd_err    = dmem.dmem_ren & (dmem.dmem_wen | ~in_range);
        rd_word   = rd_err ? 32'd0 : mem_q[idx];
        wr_word_d = merge_lanes(mem_q[idx], dmem.dmem_wdata, dmem.dmem_mask);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    // Intermediate stages p0..pN-1 between accept and the output register.
    if (READ_LATENCY > 1) begin : g_pipe
        localparam int unsigned N = READ_LATENCY - 1;

        logic [N-1:0] pvld_d, pvld_q;
        logic [N-1:0] perr_d, perr_q;
        logic [31:0]  pdata_d [N];
        logic [31:0]  pdata_q [N];

        always_comb begin
            pvld_d     = '0;
            perr_d     = '0;
            pvld_d[0]  = rd_vld;
            perr_d[0]  = rd_err;
            pdata_d[0] = rd_word;
            for (int i = 1; i < N; i++) begin
                pvld_d[i]  = pvld_q[i-1];
                perr_d[i]  = perr_q[i-1];
                pdata_d[i] = pdata_q[i-1];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                pvld_q <= '0;
                perr_q <= '0;
            end else begin
                pvld_q <= pvld_d;
                perr_q <= perr_d;
            end
        end

        always_ff @(posedge i_clk) begin
            for (int i = 0; i < N; i++) begin
                pdata_q[i] <= pdata_d[i];
            end
        end

        assign pipe_vld  = pvld_q[N-1];
        assign pipe_err  = perr_q[N-1];
        assign pipe_data = pdata_q[N-1];
    end else begin : g_direct
        assign pipe_vld  = rd_vld;
        assign pipe_err  = rd_err;
        assign pipe_data = rd_word;
    end

    // Output stage: read response, plus the one-cycle out-of-range write error.
    always_comb begin
        valid_d = pipe_vld;
        err_d   = (pipe_vld & pipe_err) | wr_err;
        rdata_d = pipe_vld ? pipe_data : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem.dmem_valid = valid_q;
    assign dmem.dmem_err   = err_q;
    assign dmem.dmem_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (READ_LATENCY 1, 2, 3)
// share one request stream; each response is checked at its exact cycle.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;

    always #5 clk = ~clk;

    dmem_if bus1 ();
    dmem_if bus2 ();
    dmem_if bus3 ();

    assign bus1.dmem_addr = addr;  assign bus1.dmem_wdata = wdata; assign bus1.dmem_mask = mask;
    assign bus1.dmem_ren  = ren;   assign bus1.dmem_wen   = wen;
    assign bus2.dmem_addr = addr;  assign bus2.dmem_wdata = wdata; assign bus2.dmem_mask = mask;
    assign bus2.dmem_ren  = ren;   assign bus2.dmem_wen   = wen;
    assign bus3.dmem_addr = addr;  assign bus3.dmem_wdata = wdata; assign bus3.dmem_mask = mask;
    assign bus3.dmem_ren  = ren;   assign bus3.dmem_wen   = wen;

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .dmem(bus1));
    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(2)) u_l2 (
        .i_clk(clk), .i_rst_n(rst_n), .dmem(bus2));
    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3)) u_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .dmem(bus3));

    logic [2:0]  vld, err;
    logic [31:0] rd [3];

    assign vld   = {bus3.dmem_valid, bus2.dmem_valid, bus1.dmem_valid};
    assign err   = {bus3.dmem_err, bus2.dmem_err, bus1.dmem_err};
    assign rd[0] = bus1.dmem_rdata;
    assign rd[1] = bus2.dmem_rdata;
    assign rd[2] = bus3.dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        rsp;
        logic [31:0] exp;
        logic        eerr;
        logic        werr;
    } slot_t;

    slot_t sl[$];

    task automatic push(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic rsp, input logic [31:0] e,
                        input logic ee, input logic we);
        slot_t s;
        s.ren = r; s.wen = w; s.addr = a; s.wdata = d; s.mask = m;
        s.rsp = rsp; s.exp = e; s.eerr = ee; s.werr = we;
        sl.push_back(s);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        push(1'b0, 1'b1, a, d, m, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr_oor(input logic [31:0] a, input logic [31:0] d);
        push(1'b0, 1'b1, a, d, 4'hF, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic rd_ok(input logic [31:0] a, input logic [31:0] e);
        push(1'b1, 1'b0, a, 32'd0, 4'h0, 1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic rd_bad(input logic [31:0] a, input logic w, input logic [31:0] d);
        push(1'b1, w, a, d, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Plays the queued slots one per cycle; instance g (latency g+1) must
    // show slot k-g's response right after edge k.
    task automatic run(input string tag);
        int n;
        int j;
        logic ev, ee;
        logic [31:0] ed;
        n = sl.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                ren = sl[k].ren; wen = sl[k].wen; addr = sl[k].addr;
                wdata = sl[k].wdata; mask = sl[k].mask;
            end else begin
                ren = 1'b0; wen = 1'b0;
            end
            cyc();
            for (int g = 0; g < 3; g++) begin
                j  = k - g;
                ev = 1'b0; ee = 1'b0; ed = 32'd0;
                if (j >= 0 && j < n) begin
                    if (sl[j].rsp) begin
                        ev = 1'b1; ee = sl[j].eerr; ed = sl[j].exp;
                    end
                end
                if (k < n) begin
                    if (sl[k].werr) ee = 1'b1;
                end
                check($sformatf("%s k%0d L%0d valid", tag, k, g + 1), 32'(vld[g]), 32'(ev));
                if (ev) check($sformatf("%s k%0d L%0d rdata", tag, k, g + 1), rd[g], ed);
                if (ev || ee) check($sformatf("%s k%0d L%0d err", tag, k, g + 1), 32'(err[g]), 32'(ee));
            end
        end
        sl.delete();
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ren = 1'b0; wen = 1'b0;
        addr = 32'd0; wdata = 32'd0; mask = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset L%0d valid", g + 1), 32'(vld[g]), 32'd0);
            check($sformatf("reset L%0d err", g + 1), 32'(err[g]), 32'd0);
            check($sformatf("reset L%0d rdata", g + 1), rd[g], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h10, 32'h0000_AA00, 4'b0010);
        rd_ok(32'h10, 32'hDEAD_AAEF);
        run("mask");

        wr(32'h0, 32'h1111_1111, 4'hF);
        wr(32'h4, 32'h2222_2222, 4'hF);
        wr(32'h8, 32'h3333_3333, 4'hF);
        rd_ok(32'h0, 32'h1111_1111);
        rd_ok(32'h4, 32'h2222_2222);
        rd_ok(32'h8, 32'h3333_3333);
        run("b2b");

        rd_ok(32'h7, 32'h2222_2222);
        run("lowbits");

        wr(32'h20, 32'hAAAA_5555, 4'hF);
        rd_ok(32'h20, 32'hAAAA_5555);
        wr(32'h20, 32'h1234_5678, 4'hF);
        rd_ok(32'h20, 32'h1234_5678);
        run("raw");

        rd_bad(TOP, 1'b0, 32'd0);
        run("oor_rd");

        wr(TOP - 32'd4, 32'h5A5A_5A5A, 4'hF);
        wr_oor(TOP, 32'hFFFF_FFFF);
        rd_ok(TOP - 32'd4, 32'h5A5A_5A5A);
        run("oor_wr");

        rd_bad(32'h0, 1'b1, 32'hCAFE_F00D);
        rd_ok(32'h0, 32'h1111_1111);
        run("illegal");

        // Two reads in flight, then asynchronous reset mid-cycle.
        ren = 1'b1; addr = 32'h0;
        cyc();
        addr = 32'h4;
        cyc();
        check("rst pre L2 valid", 32'(vld[1]), 32'd1);
        check("rst pre L2 rdata", rd[1], 32'h1111_1111);
        ren = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst async L%0d valid", g + 1), 32'(vld[g]), 32'd0);
            check($sformatf("rst async L%0d err", g + 1), 32'(err[g]), 32'd0);
            check($sformatf("rst async L%0d rdata", g + 1), rd[g], 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            for (int g = 0; g < 3; g++) begin
                check($sformatf("rst flush k%0d L%0d valid", k, g + 1), 32'(vld[g]), 32'd0);
            end
        end

        rd_ok(32'h10, 32'hDEAD_AAEF);
        rd_ok(32'h20, 32'h1234_5678);
        run("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the core's dmem request interface (address, write data, byte mask, read/write enables).
- Holds a word-organised, byte-lane-writable RAM.
- Writes retire in one cycle. Read data returns after a fixed, parameterised latency.
- Used as the data memory in core testbenches and as the on-chip scratch RAM behind the memory stage.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 2
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH
- READ_LATENCY, 1, cycles from accepted read to o_dmem_valid; legal 1..4

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_dmem_addr  in  32  byte address; bits [1:0] ignored (requester word-aligns)
- i_dmem_wdata  in  32  write data, lane k = bits [8k+7:8k]
- i_dmem_mask  in  4  byte-lane enable; bit k enables lane k
- i_dmem_ren  in  1  read request this cycle
- i_dmem_wen  in  1  write request this cycle
- o_dmem_rdata  out  32  read data, qualified by o_dmem_valid
- o_dmem_valid  out  1  one-cycle pulse per completed read
- o_dmem_err  out  1  error flag, meaningful only when o_dmem_valid=1, or on a write-error pulse

Behaviour:
- Reset:
  - Asynchronous assertion clears o_dmem_valid, o_dmem_err, o_dmem_rdata to 0 and flushes every read-pipeline stage.
  - RAM contents are not reset.
  - Deassertion is used synchronously.
  - Reads in flight when reset asserts never produce a valid.
- Request acceptance:
  - A request is accepted every cycle; no backpressure and no ready signal.
  - Fully pipelined: up to READ_LATENCY reads may be outstanding.
- Address decode:
  - word index = (i_dmem_addr - BASE_ADDR) >> 2.
  - in_range = i_dmem_addr in [BASE_ADDR, BASE_ADDR + 4*DEPTH).
- Write (i_dmem_wen=1, i_dmem_ren=0, in_range):
  - At the clock edge, each lane k with mask[k]=1 takes wdata lane k; other lanes are unchanged.
  - mask=0000 is a legal no-op.
  - No response pulse.
- Read (i_dmem_ren=1, i_dmem_wen=0, in_range):
  - The full 32-bit word is sampled at the accept edge and returned regardless of mask. The requester extracts bytes and halfwords.
  - o_dmem_valid=1 and o_dmem_rdata=word exactly READ_LATENCY cycles after the accept edge, with o_dmem_err=0.
- Read-after-write ordering:
  - A read accepted the cycle after a write to the same word returns the updated data.
  - Same-cycle write and read cannot occur (see illegal combination below).
  - A write landing while an earlier read is in flight does not alter that read's data.
- Out-of-range handling:
  - Out-of-range write: RAM is unchanged; o_dmem_err pulses high for one cycle on the next edge with o_dmem_valid=0.
  - Out-of-range read: returns o_dmem_rdata=0 and o_dmem_err=1 with o_dmem_valid, at the normal latency.
- Illegal combination (ren=1 and wen=1):
  - No RAM update.
  - Treated as an erroring read: valid and err after READ_LATENCY, rdata=0.
- Idle and back-to-back:
  - Idle cycle (ren=0, wen=0): the stage carries valid=0.
  - Back-to-back reads give back-to-back valid pulses in request order.
- Output hold: o_dmem_rdata holds its last value when valid=0. Verification must not check rdata when valid=0.
- Width rule: index uses bits [$clog2(DEPTH)+1:2] after the base subtraction; upper bits only feed in_range.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with 2 reads in flight (READ_LATENCY=2) -> valid and err drop to 0 immediately; no valid after release; prior RAM writes still readable.
- Masked write then read:
  - Write 32'hDEAD_BEEF mask 1111 to 0x10, then 32'h0000_AA00 mask 0010 -> read 0x10 returns 32'hDEAD_AAEF.
  - Valid appears exactly READ_LATENCY cycles after the request (check L=1 and L=3).
- Back-to-back pipelining:
  - Write distinct words to 0x0, 0x4, 0x8; issue reads on 3 consecutive cycles -> 3 consecutive valid pulses returning the words in order.
  - Read at addr 0x7 returns the word at 0x4 (low bits ignored).
- Read-after-write:
  - Write 32'h1234_5678 to 0x20 at cycle n, read 0x20 at n+1 -> 32'h1234_5678.
  - A read to 0x20 issued at n-1 returns the old value.
- Errors:
  - Read at BASE_ADDR+4*DEPTH -> valid=1, err=1, rdata=0.
  - Write there -> one-cycle err pulse with valid=0; a following read of word DEPTH-1 is unchanged.
  - ren=wen=1 at 0x0 -> err with valid; word 0 unchanged.
